// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry: 4x4 hex keypad scanner with debounce and 16-bit operand accumulator (accumulator built only when KEYPAD_ACCUM_EN is defined)
module keypad_operand_entry #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] operand
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_N = DW'(DEBOUNCE_SCANS);
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt, dnext;
  logic [1:0] ci, lr, low_row;
  logic [3:0] code;
  logic sample, any_low, match, accept, adv;
  assign sample = cnt == CNT_MAX;
  assign any_low = row != 4'hF;
  assign low_row = !row[0] ? 2'd0 : !row[1] ? 2'd1 : !row[2] ? 2'd2 : 2'd3;
  assign match = any_low && low_row == lr;
  assign dnext = dcnt + 1'b1;
  assign accept = sample && any_low && (state == SCAN ? DEBOUNCE_SCANS == 1 : state == DEBOUNCE && match && dnext == DB_N);
  assign adv = sample && (state == SCAN ? !any_low : state == DEBOUNCE ? !match : !any_low && dnext == DB_N);
  assign code = KEY_MAP[{low_row, ci, 2'b00} +: 4];
  // Column dwell, scan/debounce/hold sequencing and registered key outputs
  always_ff @(posedge clk)
    if (rst) begin
      state <= SCAN;
      cnt <= '0;
      dcnt <= '0;
      ci <= '0;
      lr <= '0;
      col <= 4'b1110;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      cnt <= sample ? '0 : cnt + 1'b1;
      key_valid <= accept;
      if (adv) begin
        ci <= ci + 2'd1;
        col <= ~(4'b0001 << (ci + 2'd1));
      end
      if (accept) begin
        state <= HELD;
        dcnt <= '0;
        lr <= low_row;
        key_code <= code;
        key_held <= 1'b1;
      end else if (sample)
        case (state)
          SCAN: if (any_low) begin
            state <= DEBOUNCE;
            lr <= low_row;
            dcnt <= DW'(1);
          end
          DEBOUNCE: if (match) dcnt <= dnext;
          else begin
            state <= SCAN;
            dcnt <= '0;
          end
          default: if (any_low) dcnt <= '0;
          else if (dnext == DB_N) begin
            state <= SCAN;
            dcnt <= '0;
            key_held <= 1'b0;
          end else dcnt <= dnext;
        endcase
    end
`ifdef KEYPAD_ACCUM_EN
  // Shift accepted digits in from the right; clear wins over a coincident key
  always_ff @(posedge clk)
    if (rst) operand <= '0;
    else if (clear) operand <= '0;
    else if (accept) operand <= {operand[11:0], code};
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign operand = '0;
`endif
endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Hex keypad scanner and operand accumulator for the calculator's input path. It drives the four column lines of a 4x4 matrix keypad one at a time and samples the four row lines. Each key press is debounced and reported as a single-cycle key event, and successive hex digits are shifted into a 16-bit operand. The block feeds the same `bit_input`-style 16-bit operand bus that the switch bank feeds today, so it is the input-side counterpart of the display multiplexing/driver chain.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven before the rows are sampled; legal range ≥ 2.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical samples required to accept a press or a release; legal range ≥ 1.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `row` input 4: keypad rows, active-low, externally pulled up; already synchronised upstream.
- `clear` input 1: single-cycle request to zero the operand.
- `col` output 4: column drive, active-low, exactly one bit low at all times.
- `key_code` output 4: hex value of the last accepted key.
- `key_valid` output 1: one-cycle pulse per accepted press.
- `key_held` output 1: high from acceptance until release is accepted.
- `operand` output 16: accumulated hex entry.

## Operation
- Key map, given as (row, col), low-active index: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = 0 F E D.
- Dwell counter runs 0..SCAN_DIV-1 per column. Rows are sampled on the cycle where the count equals SCAN_DIV-1.
- FSM states:
  - **SCAN**: column advances 0→1→2→3→0 after each sample. If any row is low at a sample, latch the column and the lowest-index low row, set the debounce count to 1, and go to DEBOUNCE. The column is held.
  - **DEBOUNCE**: each sample that matches the latched row increments the count. When the count reaches DEBOUNCE_SCANS, go to HELD, load `key_code`, pulse `key_valid`, and set `key_held`. On a mismatch (row released or a different row), return to SCAN with the column advanced.
  - **HELD**: column stays on the latched column. Each sample with all rows high increments a release count; any low row resets it to 0. When the release count reaches DEBOUNCE_SCANS, clear `key_held` and go to SCAN with the column advanced.
- With DEBOUNCE_SCANS = 1, DEBOUNCE is left on the same sample that enters it; the first low sample is accepted.
- Multiple keys pressed: only the first-detected column is serviced; within it, the lowest row wins. Other keys are ignored until release.
- Operand update on `key_valid`: `operand <= {operand[11:0], key_code}`. The oldest digit is discarded; there is no saturation.
- `clear` zeroes `operand` in the next cycle. If `clear` coincides with an accepted key, `clear` has priority: operand becomes 0 and the digit is discarded. `key_valid` and `key_code` are unaffected.

## Timing
- Reset values: `col` = 4'b1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0, `operand` = 0. FSM in SCAN at column 0, all counters 0.
- Reset mid-debounce or mid-hold abandons the key. No `key_valid` is produced for it and no release is reported.
- All outputs are registered.
- `key_valid`, `key_code`, `key_held` and `operand` change one cycle after the accepting sample edge.
- Minimum press-to-event latency: DEBOUNCE_SCANS × SCAN_DIV cycles after the column with the pressed key is first driven, plus 1 cycle.
- `col` changes in the cycle after a sample; it never has zero or two bits low.

## Configuration
- `KEYPAD_ACCUM_EN` defined: operand shift register and `clear` handling are compiled in, as described above.
- `KEYPAD_ACCUM_EN` undefined: no accumulator.
  - `operand` is tied to 16'h0000 and `clear` is ignored.
  - Scanner, debounce, `key_code`, `key_valid` and `key_held` are unchanged.

## Test plan
Bench uses SCAN_DIV = 4, DEBOUNCE_SCANS = 3, with the macro defined unless noted.
- **Single press:** hold key 5 (row1 low while col1 low) until released, then release → exactly one `key_valid` pulse, `key_code` = 4'h5, `operand` = 16'h0005, and `key_held` falls after 3 all-high samples.
- **Bounce rejection:** row0 low for 2 samples on col2, then high → no `key_valid`, scan resumes at col3, `operand` stays 0.
- **Entry sequence:** press 1, 2, 3, 4, 5 → `operand` reads 0x0001, 0x0012, 0x0123, 0x1234, 0x2345 in turn.
- **Clear collision:** `clear` asserted in the same cycle as the acceptance of key A → `operand` = 0 and `key_valid` pulses with `key_code` = 4'hA.
- **Reset mid-hold:** `rst` during HELD on key 9 → all outputs at reset values, `col` = 4'b1110, no further pulse while key 9 stays held until its column is next scanned, then a fresh debounce.
- **Macro off:** repeat the entry sequence → `key_valid` and `key_code` are identical to the macro-on run and `operand` stays 0.
